// File: rtl/isqrt_pkg.sv
// Shared definitions for the sequential integer square-root unit:
// FSM encoding plus width helpers derived from the operand width.
package isqrt_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int root_width(input int w);
        return w / 2;
    endfunction

    // Iteration counter only ever holds R-1, but it must stay at least one bit wide.
    function automatic int cnt_width(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One combinational digit of the restoring square root: brings down two
// operand bits and decides the next root bit.
module isqrt_step #(
    parameter int R = 4
) (
    input  logic [R+1:0] rem_in,
    input  logic [R-1:0] root_in,
    input  logic [1:0]   bits,
    output logic [R+1:0] rem_out,
    output logic [R-1:0] root_out
);

    logic [R+3:0] t;
    logic [R+3:0] trial;
    logic         fits;

    // Intermediates are kept two bits wider than rem_in so the shift never drops bits.
    always_comb begin
        t        = {rem_in, bits};
        trial    = {2'b00, root_in, 2'b01};
        fits     = (t >= trial);
        rem_out  = fits ? (R+2)'(t - trial) : t[R+1:0];
        root_out = fits ? ((root_in << 1) | R'(1)) : (root_in << 1);
    end

endmodule

// File: rtl/isqrt_seq.sv
// Multi-cycle integer square root: one root bit per clock, with a
// start/busy/done handshake and results held until the next completion.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [W-1:0]   a,
    output logic           busy,
    output logic           done,
    output logic [W/2-1:0] sqrt,
    output logic [W/2:0]   rem
);

    localparam int R  = root_width(W);
    localparam int CW = cnt_width(R);

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  opnd_reg;
    logic [R-1:0]  root_reg;
    logic [R+1:0]  remw_reg;
    logic [R-1:0]  sqrt_reg;
    logic [R:0]    rem_reg;

    logic [R+1:0]  remw_next;
    logic [R-1:0]  root_next;

    isqrt_step #(.R(R)) u_step (
        .rem_in   (remw_reg),
        .root_in  (root_reg),
        .bits     (opnd_reg[W-1:W-2]),
        .rem_out  (remw_next),
        .root_out (root_next)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            opnd_reg  <= '0;
            root_reg  <= '0;
            remw_reg  <= '0;
            sqrt_reg  <= '0;
            rem_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        opnd_reg  <= a;
                        root_reg  <= '0;
                        remw_reg  <= '0;
                        cnt_reg   <= CW'(R - 1);
                        state_reg <= CALC;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    remw_reg <= remw_next;
                    root_reg <= root_next;
                    opnd_reg <= opnd_reg << 2;
                    // Final digit publishes straight from the step so results appear with done.
                    if (cnt_reg == '0) begin
                        sqrt_reg  <= root_next;
                        rem_reg   <= remw_next[R:0];
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == CALC);
    assign done = (state_reg == DONE);
    assign sqrt = sqrt_reg;
    assign rem  = rem_reg;

endmodule

// File: doc/isqrt_seq.md
Name: isqrt_seq

Overview:
- Parametrised, multi-cycle integer square root with start/busy/done handshake.
- Computes floor(sqrt(a)) and remainder a - sqrt^2 for a W-bit unsigned operand, one result bit per clock, using the digit-by-digit restoring method.
- Successor to the fixed 8-bit controller/datapath square-root unit; adds width generality, remainder output, a busy/done handshake and held results.
- Drop-in compute leaf for lab-level tops driven by switches/buttons or by a sequencing FSM.

Parameters:
- W, 8, operand width in bits; must be even and >= 2. Root width R = W/2; remainder width R+1.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- start  in  1  request; sampled only when busy=0.
- a  in  W  unsigned operand; sampled on the accepting edge only.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse: result registers were just updated.
- sqrt  out  R  floor(sqrt(a)) of the last completed operation.
- rem  out  R+1  a - sqrt*sqrt of the last completed operation; always <= 2*sqrt.

Behaviour:
- Reset (clr=1 at a rising edge):
  - state <= IDLE; busy=0, done=0, sqrt=0, rem=0.
  - Working registers are cleared.
  - clr overrides start and any in-flight computation; a partial result is never published.
- FSM states: IDLE, CALC, DONE.
  - IDLE: busy=0. If start=1: latch a into the shift register, clear root/partial remainder, load iteration counter with R-1, and go to CALC.
  - CALC: busy=1. Run one iteration per cycle (see Iteration). When counter = 0 on this edge, go to DONE; otherwise decrement the counter.
  - DONE: busy=0, done=1 for exactly this cycle. sqrt/rem registers were loaded on the edge entering DONE. If start=1, accept a new operand exactly as in IDLE and go to CALC (back-to-back). Otherwise go to IDLE.
- Latency:
  - start accepted at edge N; CALC occupies edges N+1..N+R; done is high during the cycle after edge N+R.
  - Throughput: one result per R+1 cycles.
- Iteration (working remainder is R+2 bits; root is R bits):
  - t = (rem_w << 2) | next two MSBs of the operand shift register.
  - trial = (root << 2) | 1.
  - If t >= trial: rem_w <= t - trial and root <= (root << 1) | 1.
  - Else: rem_w <= t and root <= root << 1.
  - Shift the operand left by 2.
  - All arithmetic is unsigned; the final rem_w fits in R+1 bits, and the upper bit is truncated on publish.
- Handshake rules:
  - start while busy=1 is ignored; no queueing.
  - a may change freely after the accepting edge.
  - sqrt/rem hold their previous values throughout CALC and change only on the edge entering DONE.
- Boundaries:
  - a=0 gives sqrt=0, rem=0.
  - a=2^W-1 gives sqrt=2^R-1, rem=2^(R+1)-2, with no overflow.
  - W=2 gives R=1 and a single CALC cycle.
  - start held continuously produces back-to-back operations, with done pulsing every R+1 cycles.
  - clr asserted in the same cycle as start leaves the block in IDLE.

Decomposition:
- Package isqrt_pkg:
  - State encoding for IDLE/CALC/DONE (2-bit).
  - Helper constant functions for R and counter width clog2(R), minimum 1.
- Sub-module isqrt_step:
  - Purely combinational single iteration.
  - Inputs: rem_w, root, two operand bits. Outputs: next rem_w, next root.
  - Parametrised by R.
- isqrt_seq holds the FSM, counter and registers, and instantiates one isqrt_step.

Test Plan:
- W=8: clr, then start with a=144 -> busy high 4 cycles, done pulse on the 5th cycle after accept; sqrt=12, rem=0.
- W=8: a=143 -> sqrt=11, rem=22. Then a=255 -> sqrt=15, rem=30. Then a=0 -> sqrt=0, rem=0. Results hold between operations.
- W=8: start a=200, pulse start again with a=9 during CALC -> second start ignored; only one done; sqrt=14, rem=4.
- W=8: start a=255, assert clr on the 2nd CALC cycle -> next cycle busy=0, done never pulses, sqrt=0, rem=0.
- W=8: start held high with a=100, then a=81 presented on the DONE cycle -> done pulses every 5 cycles; first result 10/0, second 9/0.
- W=16: a=65535 -> sqrt=255, rem=510 after 8 CALC cycles. W=2: a=3 -> sqrt=1, rem=2 after 1 CALC cycle. Random sweep checks sqrt^2 <= a < (sqrt+1)^2 and rem = a - sqrt^2.
